// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: shares one fixed-latency, fully pipelined single-precision
// add/sub unit between NUM_REQ requesters. A round-robin arbiter issues at most
// one op per cycle, a tag shift register routes each result back to its owner,
// and a drain FSM stops issue and reports when the pipeline is empty.
// Optional macro FP_SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round robin; the RR pointer is removed.
`timescale 1ns/1ps
module fp_addsub_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_dataa,
  input  logic [32*NUM_REQ-1:0] req_datab,
  input  logic [NUM_REQ-1:0]   req_sub,
  input  logic                 drain_req,
  output logic [31:0]          fpu_dataa,
  output logic [31:0]          fpu_datab,
  input  logic [31:0]          fpu_result,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  output logic                 drained,
  output logic [3:0]           inflight
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [31:0]          w_a [NUM_REQ];
  logic [31:0]          w_b [NUM_REQ];

  logic [NUM_REQ-1:0]   w_grant;
  logic [IDW-1:0]       w_gnt_id;
  logic [IDW-1:0]       w_cand;
  logic                 w_found;
  logic                 w_accept;
  logic                 w_tag_out;

  logic [31:0]          r_fpu_a;
  logic [31:0]          r_fpu_b;
  logic [LATENCY-1:0]   r_tag_vld;
  logic [IDW-1:0]       r_tag_id [LATENCY];
  logic                 r_pend_vld;
  logic [IDW-1:0]       r_pend_id;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [IDW-1:0]       r_resp_id;
  logic [31:0]          r_resp_data;
  logic [3:0]           r_inflight;

`ifndef FP_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]       r_ptr;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a[g] = req_dataa[32*g +: 32];
    assign w_b[g] = req_datab[32*g +: 32];
  end

  // Arbiter: pick the first valid requester after the pointer (or lowest index); only in RUN with no drain request
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    if (r_state == ST_RUN && !drain_req) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef FP_SCHED_FIXED_PRIO_EN
        w_cand = IDW'(k);
`else
        w_cand = IDW'((32'(r_ptr) + k + 32'd1) % 32'(NUM_REQ));
`endif
        if (!w_found && req_valid[w_cand]) begin
          w_found  = 1'b1;
          w_gnt_id = w_cand;
        end
      end
      if (w_found) begin
        w_grant = NUM_REQ'(1) << w_gnt_id;
      end
    end
  end

  assign w_accept  = w_found;
  assign w_tag_out = r_tag_vld[LATENCY-1];

`ifndef FP_SCHED_FIXED_PRIO_EN
  // Round-robin pointer remembers the last accepted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IDW'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_gnt_id;
    end
  end
`endif

  // Operand registers to the shared unit; B sign flipped for subtract
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpu_a <= '0;
      r_fpu_b <= '0;
    end else if (w_accept) begin
      r_fpu_a <= w_a[w_gnt_id];
      r_fpu_b <= {w_b[w_gnt_id][31] ^ req_sub[w_gnt_id], w_b[w_gnt_id][30:0]};
    end
  end

  // Tag shift register tracks owner of each in-flight op, plus one pending stage aligned to fpu_result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld  <= '0;
      r_pend_vld <= 1'b0;
      r_pend_id  <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[LATENCY-2:0], w_accept};
      r_tag_id[0] <= w_gnt_id;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
      r_pend_vld <= w_tag_out;
      r_pend_id  <= r_tag_id[LATENCY-1];
    end
  end

  // Response register: capture the unit result for the pending tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= '0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else if (r_pend_vld) begin
      r_resp_valid <= NUM_REQ'(1) << r_pend_id;
      r_resp_id    <= r_pend_id;
      r_resp_data  <= fpu_result;
    end else begin
      r_resp_valid <= '0;
    end
  end

  // In-flight counter: up on accept, down when a valid tag leaves the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_tag_out})
        2'b10:   r_inflight <= r_inflight + 4'd1;
        2'b01:   r_inflight <= r_inflight - 4'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Drain FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Drain FSM next-state: HALT only once no tag and no pending response remain
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (drain_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)                             w_state_nxt = ST_RUN;
        else if (r_inflight == 4'd0 && !r_pend_vld) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (!drain_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  assign req_ready  = w_grant;
  assign fpu_dataa  = r_fpu_a;
  assign fpu_datab  = r_fpu_b;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign drained    = (r_state == ST_HALT);
  assign inflight   = r_inflight;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Scoreboard bench for fp_addsub_sched with a behavioural 7-stage FP add unit.
`timescale 1ns/1ps
module tb_fp_addsub_sched;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int LATENCY = 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_dataa;
  logic [32*NUM_REQ-1:0] req_datab;
  logic [NUM_REQ-1:0]    req_sub;
  logic                  drain_req;
  logic [31:0]           fpu_dataa, fpu_datab, fpu_result;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [31:0]           resp_data;
  logic                  drained;
  logic [3:0]            inflight;

  logic [31:0] sa [NUM_REQ];
  logic [31:0] sbv [NUM_REQ];
  logic        ssub [NUM_REQ];
  logic [31:0] exp_res [NUM_REQ];

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    int unsigned    cyc;
  } exp_t;

  exp_t        sbq [$];
  exp_t        mon_e;
  int unsigned resp_cyc [$];
  int unsigned resp_cnt = 0;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  fp_addsub_sched #(.NUM_REQ(NUM_REQ), .IDW(IDW), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dataa(req_dataa), .req_datab(req_datab), .req_sub(req_sub),
    .drain_req(drain_req), .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab),
    .fpu_result(fpu_result), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .drained(drained), .inflight(inflight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_dataa = '0;
    req_datab = '0;
    req_sub   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dataa[32*i +: 32] = sa[i];
      req_datab[32*i +: 32] = sbv[i];
      req_sub[i]            = ssub[i];
    end
  end

  function automatic real sp2real(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'd0) return 0.0;
    d = {v[31], 11'(v[30:23]) + 11'd896, v[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Shared unit model: always adds, LATENCY-stage pipe
  logic [31:0] upipe [LATENCY];
  always @(posedge clk) begin
    upipe[0] <= real2sp(sp2real(fpu_dataa) + sp2real(fpu_datab));
    for (int k = 1; k < LATENCY; k++) upipe[k] <= upipe[k-1];
  end
  assign fpu_result = upipe[LATENCY-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Accept observer: push the hand-computed result for the requester being accepted
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i])
          sbq.push_back('{id: IDW'(i), data: exp_res[i], cyc: cyc});
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && resp_valid != '0) begin
      resp_cnt++;
      resp_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(NUM_REQ'(1) << mon_e.id));
        chk("resp_id", 32'(resp_id), 32'(mon_e.id));
        chk("resp_data", resp_data, mon_e.data);
        chk("resp_latency", cyc - mon_e.cyc, LATENCY + 2);
      end
    end
  end

  task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] r);
    sa[id] = a; sbv[id] = b; ssub[id] = s; exp_res[id] = r;
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accept edge
  task automatic issue_one(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] bx, input logic [31:0] r);
    bit got = 0;
    set_op(id, a, b, s, r);
    req_valid[id] = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      chk("grant_timeout", 32'd0, 32'd1);
      req_valid[id] = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      chk("fpu_dataa", fpu_dataa, a);
      chk("fpu_datab", fpu_datab, bx);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (inflight == 4'd0 && resp_valid == '0 && sbq.size() == 0) ok = 1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  int unsigned exp_order [8];
  int unsigned seq [$];
  int unsigned exp_seq [4] = '{3, 2, 1, 0};
  logic [NUM_REQ-1:0] g;
  int unsigned got;
  int unsigned cnt_before;

  initial begin
    rst_n = 1'b0; req_valid = '0; drain_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'd0, 32'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fpu_dataa", fpu_dataa, 32'd0);
    chk("rst_fpu_datab", fpu_datab, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin with all four held valid for 8 grants
`ifdef FP_SCHED_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    set_op(1, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);
    set_op(3, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000);
    resp_cyc.delete();
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'(NUM_REQ'(1) << exp_order[c]));
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle();
    chk("rr_resp_count", resp_cyc.size(), 8);
    if (resp_cyc.size() == 8) chk("rr_resp_span", resp_cyc[7] - resp_cyc[0], 7);

    // Single add and subtract
    issue_one(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000);
    wait_idle();
    issue_one(2, 32'h40A00000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40800000);
    wait_idle();

    // Idle gap: accept, 3 idle cycles, accept; 2.0 - 2.0 gives +0
    resp_cyc.delete();
    issue_one(1, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_hold_dataa", fpu_dataa, 32'h3F800000);
      @(posedge clk); #1;
    end
    issue_one(1, 32'h40000000, 32'h40000000, 1'b1, 32'hC0000000, 32'h00000000);
    wait_idle();
    chk("gap_resp_count", resp_cyc.size(), 2);
    if (resp_cyc.size() == 2) chk("gap_resp_spacing", resp_cyc[1] - resp_cyc[0], 4);

    // Drain with 3 ops in flight
    set_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    set_op(1, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000);
    set_op(2, 32'h40C00000, 32'h40000000, 1'b1, 32'h40800000);
    set_op(3, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    req_valid = 4'b0111;
    got = 0;
    for (int n = 0; n < 20 && got < 3; n++) begin
      @(negedge clk);
      g = req_ready;
      if (g != '0) got++;
      @(posedge clk); #1;
      req_valid = req_valid & ~g;
    end
    chk("drain_pre_inflight", 32'(inflight), 32'd3);
    drain_req = 1'b1;
    req_valid[3] = 1'b1;
    seq.delete();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      chk("drain_ready_low", 32'(req_ready), 32'd0);
      if (seq.size() == 0 || seq[seq.size()-1] != 32'(inflight)) seq.push_back(32'(inflight));
      if (drained) break;
      @(posedge clk); #1;
    end
    chk("drain_seq_len", seq.size(), 4);
    if (seq.size() == 4)
      for (int k = 0; k < 4; k++) chk("drain_inflight_seq", seq[k], exp_seq[k]);
    chk("drained_high", 32'(drained), 32'd1);
    chk("drain_sb_empty", sbq.size(), 0);
    @(posedge clk); #1;
    drain_req = 1'b0;
    @(negedge clk);
    chk("halt_ready_low", 32'(req_ready), 32'd0);
    chk("halt_drained", 32'(drained), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resume_grant", 32'(req_ready), 32'h8);
    chk("resume_drained", 32'(drained), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Reset with 5 ops in flight
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
    set_op(1, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);
    set_op(3, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000);
    req_valid = '1;
    got = 0;
    for (int n = 0; n < 20 && got < 5; n++) begin
      @(negedge clk);
      if (req_ready != '0) got++;
      @(posedge clk); #1;
    end
    chk("rstmid_pre_inflight", 32'(inflight), 32'd5);
    rst_n = 1'b0;
    req_valid = '0;
    sbq.delete();
    #1;
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid_inflight", 32'(inflight), 32'd0);
    chk("rstmid_fpu_dataa", fpu_dataa, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt_before = resp_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("rstmid_no_stale", resp_cnt - cnt_before, 0);
    chk("rstmid_inflight_after", 32'(inflight), 32'd0);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("rstmid_first_prio", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rstmid_second_grant", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    chk("final_sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
